// File: rtl/fma_round_pipe.sv
// -----------------------------------------------------------------------------
// fma_round_pipe
//
// Two-stage rounding pipeline for the FMA datapath. It takes a normalised,
// pre-rounding sum (sign, biased exponent with one headroom bit, fraction,
// guard/round/sticky) and produces the packed IEEE-style result with per-result
// overflow/inexact flags. A valid/ready handshake provides full backpressure.
// The block also accumulates sticky {OF, NX} flags and counts round-up events.
//
// Parameters
//   NE  exponent width
//   NF  stored fraction width (hidden one implied)
//   CW  width of the saturating round-up counter
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/ready    input handshake; in_ready is combinational from out_ready
//   in_sign/exp/frac  normalised operand; in_exp[NE] is overflow headroom
//   in_grs            {guard, round, sticky}
//   in_mode           000 RZ, 001 RNE, 010 RN, 011 RP, 100 RNA, others RZ
//   in_bypass(_val)   pass a special value (NaN/inf/zero) through unrounded
//   out_valid/ready   output handshake; outputs hold while stalled
//   out_result        {sign, exp, frac}
//   out_of/out_nx     overflow / inexact for the presented result
//   flags_acc         {OF, NX} ORed over completed transactions
//   flags_clr         synchronous clear of flags_acc (applied before the OR)
//   roundup_cnt       completed non-bypass transactions that rounded up
// -----------------------------------------------------------------------------
module fma_round_pipe #(
    parameter int NE = 5,
    parameter int NF = 10,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [NE:0]      in_exp,
    input  logic [NF-1:0]    in_frac,
    input  logic [2:0]       in_grs,
    input  logic [2:0]       in_mode,
    input  logic             in_bypass,
    input  logic [NE+NF:0]   in_bypass_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NE+NF:0]   out_result,
    output logic             out_of,
    output logic             out_nx,
    output logic [1:0]       flags_acc,
    input  logic             flags_clr,
    output logic [CW-1:0]    roundup_cnt
);

    typedef enum logic [2:0] {
        MODE_RZ  = 3'b000,
        MODE_RNE = 3'b001,
        MODE_RN  = 3'b010,
        MODE_RP  = 3'b011,
        MODE_RNA = 3'b100
    } round_mode_e;

    // Smallest exponent that no longer encodes a finite value.
    localparam logic [NE:0] EXP_OVF = {1'b0, {NE{1'b1}}};

    // ------------------------------------------------------------------ state
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [2:0]        s1_mode_q,  s1_mode_d;
    logic              s1_bypass_q, s1_bypass_d;
    logic              s1_up_q,    s1_up_d;
    logic              s1_nx_q,    s1_nx_d;
    logic [NF-1:0]     s1_frac_q,  s1_frac_d;
    logic [NE:0]       s1_exp_q,   s1_exp_d;
    logic [NE+NF:0]    s1_bval_q,  s1_bval_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_count_q, s2_count_d;
    logic [NE+NF:0]    out_result_q, out_result_d;
    logic              out_of_q,   out_of_d;
    logic              out_nx_q,   out_nx_d;

    logic [1:0]        flags_acc_q, flags_acc_d;
    logic [CW-1:0]     roundup_cnt_q, roundup_cnt_d;

    // -------------------------------------------------------------- handshake
    logic s2_adv, accept, done;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_adv;
    assign accept   = in_valid & in_ready;
    assign done     = s2_valid_q & out_ready;

    // ------------------------------------------------- stage 1: round decision
    logic          g_bit, x_bit, up;
    logic [NF:0]   frac_sum;
    logic [NE+1:0] exp_sum;
    logic [NE:0]   exp1;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // value on every path (here via the case default) so no latch is inferred.
    always_comb begin
        g_bit = in_grs[2];
        x_bit = in_grs[1] | in_grs[0];
        case (round_mode_e'(in_mode))
            MODE_RNE: up = g_bit & (in_frac[0] | x_bit);
            MODE_RNA: up = g_bit;
            MODE_RP:  up = ~in_sign & (g_bit | x_bit);
            MODE_RN:  up = in_sign & (g_bit | x_bit);
            default:  up = 1'b0;
        endcase
        frac_sum = {1'b0, in_frac} + {{NF{1'b0}}, up};
        exp_sum  = {1'b0, in_exp} + {{(NE+1){1'b0}}, frac_sum[NF]};
        // A carry out of the headroom bit would wrap back to a small exponent;
        // pin it at all-ones instead, which still reads as overflow.
        exp1     = exp_sum[NE+1] ? {(NE+1){1'b1}} : exp_sum[NE:0];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_mode_d   = s1_mode_q;
        s1_bypass_d = s1_bypass_q;
        s1_up_d     = s1_up_q;
        s1_nx_d     = s1_nx_q;
        s1_frac_d   = s1_frac_q;
        s1_exp_d    = s1_exp_q;
        s1_bval_d   = s1_bval_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        // Data registers only move on an actual transfer.
        if (accept) begin
            s1_sign_d   = in_sign;
            s1_mode_d   = in_mode;
            s1_bypass_d = in_bypass;
            s1_up_d     = up;
            s1_nx_d     = |in_grs;
            s1_frac_d   = frac_sum[NF-1:0];
            s1_exp_d    = exp1;
            s1_bval_d   = in_bypass_val;
        end
    end

    // ------------------------------------------ stage 2: overflow and packing
    logic           ovf, to_inf;
    logic [NE+NF:0] res;
    logic           res_of, res_nx;

    always_comb begin
        ovf = (s1_exp_q >= EXP_OVF);
        case (round_mode_e'(s1_mode_q))
            MODE_RNE, MODE_RNA: to_inf = 1'b1;
            MODE_RP:            to_inf = ~s1_sign_q;
            MODE_RN:            to_inf = s1_sign_q;
            default:            to_inf = 1'b0;
        endcase

        if (s1_bypass_q) begin
            res    = s1_bval_q;
            res_of = 1'b0;
            res_nx = 1'b0;
        end else if (ovf) begin
            // Modes that round away from the overflow direction saturate to
            // the largest finite magnitude instead of infinity.
            res    = to_inf ? {s1_sign_q, {NE{1'b1}}, {NF{1'b0}}}
                            : {s1_sign_q, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
            res_of = 1'b1;
            res_nx = 1'b1;
        end else begin
            res    = {s1_sign_q, s1_exp_q[NE-1:0], s1_frac_q};
            res_of = 1'b0;
            res_nx = s1_nx_q;
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_count_d   = s2_count_q;
        out_result_d = out_result_q;
        out_of_d     = out_of_q;
        out_nx_d     = out_nx_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        // Outputs stay frozen while the consumer stalls.
        if (s2_adv && s1_valid_q) begin
            s2_count_d   = s1_up_q & ~s1_bypass_q;
            out_result_d = res;
            out_of_d     = res_of;
            out_nx_d     = res_nx;
        end
    end

    // ------------------------------------------------ completion bookkeeping
    always_comb begin
        // Clear is applied first so a completing transaction still lands.
        flags_acc_d = (flags_clr ? 2'b00 : flags_acc_q)
                    | (done ? {out_of_q, out_nx_q} : 2'b00);
        roundup_cnt_d = roundup_cnt_q;
        if (done && s2_count_q && !(&roundup_cnt_q)) begin
            roundup_cnt_d = roundup_cnt_q + CW'(1);
        end
    end

    // ----------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mode_q     <= 3'b000;
            s1_bypass_q   <= 1'b0;
            s1_up_q       <= 1'b0;
            s1_nx_q       <= 1'b0;
            s1_frac_q     <= '0;
            s1_exp_q      <= '0;
            s1_bval_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_count_q    <= 1'b0;
            out_result_q  <= '0;
            out_of_q      <= 1'b0;
            out_nx_q      <= 1'b0;
            flags_acc_q   <= 2'b00;
            roundup_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_mode_q     <= s1_mode_d;
            s1_bypass_q   <= s1_bypass_d;
            s1_up_q       <= s1_up_d;
            s1_nx_q       <= s1_nx_d;
            s1_frac_q     <= s1_frac_d;
            s1_exp_q      <= s1_exp_d;
            s1_bval_q     <= s1_bval_d;
            s2_valid_q    <= s2_valid_d;
            s2_count_q    <= s2_count_d;
            out_result_q  <= out_result_d;
            out_of_q      <= out_of_d;
            out_nx_q      <= out_nx_d;
            flags_acc_q   <= flags_acc_d;
            roundup_cnt_q <= roundup_cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = out_result_q;
    assign out_of      = out_of_q;
    assign out_nx      = out_nx_q;
    assign flags_acc   = flags_acc_q;
    assign roundup_cnt = roundup_cnt_q;

endmodule

// File: tb/tb_fma_round_pipe.sv
// -----------------------------------------------------------------------------
// tb_fma_round_pipe
//
// Scoreboard bench for fma_round_pipe (NE=5, NF=10, CW=2 so counter saturation
// is reachable). The driver records the expected result alongside each
// stimulus; the monitor pushes it on input handshake and pops/compares it on
// output handshake, while tracking the expected sticky flags and counter.
// -----------------------------------------------------------------------------
module tb_fma_round_pipe;

    localparam int NE = 5;
    localparam int NF = 10;
    localparam int CW = 2;

    localparam logic [2:0] RZ  = 3'd0;
    localparam logic [2:0] RNE = 3'd1;
    localparam logic [2:0] RN  = 3'd2;
    localparam logic [2:0] RP  = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_sign = 1'b0;
    logic [NE:0]    in_exp = '0;
    logic [NF-1:0]  in_frac = '0;
    logic [2:0]     in_grs = '0;
    logic [2:0]     in_mode = '0;
    logic           in_bypass = 1'b0;
    logic [NE+NF:0] in_bypass_val = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [NE+NF:0] out_result;
    logic           out_of;
    logic           out_nx;
    logic [1:0]     flags_acc;
    logic           flags_clr = 1'b0;
    logic [CW-1:0]  roundup_cnt;

    fma_round_pipe #(.NE(NE), .NF(NF), .CW(CW)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_frac       (in_frac),
        .in_grs        (in_grs),
        .in_mode       (in_mode),
        .in_bypass     (in_bypass),
        .in_bypass_val (in_bypass_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_of        (out_of),
        .out_nx        (out_nx),
        .flags_acc     (flags_acc),
        .flags_clr     (flags_clr),
        .roundup_cnt   (roundup_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        nx;
        logic        up;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t drv_exp = '0;
    exp_t mon_e;
    logic [1:0] m_flags = 2'b00;
    logic [1:0] m_cnt = 2'b00;
    int   accepted = 0;
    int   emitted = 0;
    bit   bp_done;
    bit   rnd_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic o, input logic n, input logic u);
        exp_t e;
        e.res = r; e.ovf = o; e.nx = n; e.up = u;
        return e;
    endfunction

    // Reference rounding for binary16, done on integers.
    function automatic exp_t model(input logic s, input logic [5:0] e, input logic [9:0] f,
                                   input logic [2:0] grs, input logic [2:0] m,
                                   input logic byp, input logic [15:0] bv);
        exp_t r;
        bit   g, rest, rnd, to_inf;
        int   mant, ex;
        g    = grs[2];
        rest = grs[1] | grs[0];
        case (m)
            3'd1:    rnd = g && (f[0] || rest);
            3'd2:    rnd = s && (g || rest);
            3'd3:    rnd = !s && (g || rest);
            3'd4:    rnd = g;
            default: rnd = 1'b0;
        endcase
        mant = int'(f) + (rnd ? 1 : 0);
        ex   = int'(e);
        if (mant > 1023) begin
            mant -= 1024;
            ex   += 1;
        end
        r.up = rnd && !byp;
        if (byp) begin
            r.res = bv; r.ovf = 1'b0; r.nx = 1'b0;
        end else if (ex >= 31) begin
            to_inf = (m == 3'd1) || (m == 3'd4) || (m == 3'd3 && !s) || (m == 3'd2 && s);
            r.res  = to_inf ? {s, 15'h7C00} : {s, 15'h7BFF};
            r.ovf  = 1'b1; r.nx = 1'b1;
        end else begin
            r.res = {s, 5'(ex), 10'(mant)};
            r.ovf = 1'b0; r.nx = g || rest;
        end
        return r;
    endfunction

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            m_flags = 2'b00;
            m_cnt   = 2'b00;
        end else begin
            check("flags_acc", {30'd0, flags_acc}, {30'd0, m_flags});
            check("roundup_cnt", {30'd0, roundup_cnt}, {30'd0, m_cnt});
            if (in_valid && in_ready) begin
                sb_q.push_back(drv_exp);
                accepted++;
            end
            if (out_valid && out_ready) begin
                emitted++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_result", {16'd0, out_result}, {16'd0, mon_e.res});
                    check("out_of", {31'd0, out_of}, {31'd0, mon_e.ovf});
                    check("out_nx", {31'd0, out_nx}, {31'd0, mon_e.nx});
                    m_flags = (flags_clr ? 2'b00 : m_flags) | {mon_e.ovf, mon_e.nx};
                    if (mon_e.up && m_cnt != 2'b11) m_cnt = m_cnt + 2'b01;
                end
            end else if (flags_clr) begin
                m_flags = 2'b00;
            end
        end
    end

    task automatic send(input logic s, input logic [5:0] e, input logic [9:0] f,
                        input logic [2:0] grs, input logic [2:0] m, input logic byp,
                        input logic [15:0] bv, input exp_t want);
        bit ok = 1'b0;
        in_sign = s; in_exp = e; in_frac = f; in_grs = grs; in_mode = m;
        in_bypass = byp; in_bypass_val = bv; drv_exp = want;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic s, input logic [5:0] e, input logic [9:0] f,
                          input logic [2:0] grs, input logic [2:0] m);
        send(s, e, f, grs, m, 1'b0, 16'h0000, model(s, e, f, grs, m, 1'b0, 16'h0000));
    endtask

    task automatic send_rand();
        logic s, byp;
        logic [5:0] e;
        logic [9:0] f;
        logic [2:0] grs, m;
        logic [15:0] bv;
        s   = 1'($urandom_range(0, 1));
        e   = 6'($urandom_range(1, 33));
        f   = 10'($urandom);
        grs = 3'($urandom);
        m   = 3'($urandom_range(0, 7));
        byp = ($urandom_range(0, 7) == 0);
        bv  = 16'($urandom);
        send(s, e, f, grs, m, byp, bv, model(s, e, f, grs, m, byp, bv));
    endtask

    task automatic drain();
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [15:0] hold;
        int snap;

        // Reset state
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_of_nx", {30'd0, out_of, out_nx}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags", {30'd0, flags_acc}, 32'd0);
        check("rst_cnt", {30'd0, roundup_cnt}, 32'd0);

        // RNE tie stays, RNA tie rounds away
        send(1'b0, 6'd15, 10'h000, 3'b100, RNE, 1'b0, 16'h0, mk(16'h3C00, 1'b0, 1'b1, 1'b0));
        send(1'b0, 6'd15, 10'h000, 3'b100, RNA, 1'b0, 16'h0, mk(16'h3C01, 1'b0, 1'b1, 1'b1));
        drain();
        check("rna_count", {30'd0, roundup_cnt}, 32'd1);

        // Fraction carry into exponent, overflow by mode
        send(1'b0, 6'd14, 10'h3FF, 3'b110, RNE, 1'b0, 16'h0, mk(16'h3C00, 1'b0, 1'b1, 1'b1));
        send(1'b0, 6'd30, 10'h3FF, 3'b110, RNE, 1'b0, 16'h0, mk(16'h7C00, 1'b1, 1'b1, 1'b1));
        send(1'b0, 6'd30, 10'h3FF, 3'b110, RZ,  1'b0, 16'h0, mk(16'h7BFF, 1'b0, 1'b1, 1'b0));
        send(1'b1, 6'd30, 10'h3FF, 3'b110, RP,  1'b0, 16'h0, mk(16'hFBFF, 1'b0, 1'b1, 1'b0));
        send(1'b1, 6'd31, 10'h3FF, 3'b110, RP,  1'b0, 16'h0, mk(16'hFBFF, 1'b1, 1'b1, 1'b0));
        send(1'b1, 6'd30, 10'h3FF, 3'b110, RN,  1'b0, 16'h0, mk(16'hFC00, 1'b1, 1'b1, 1'b1));
        drain();

        // Sticky flags: clear, inexact then exact
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        check("flags_cleared", {30'd0, flags_acc}, 32'd0);
        send(1'b0, 6'd15, 10'h005, 3'b001, RZ,  1'b0, 16'h0, mk(16'h3C05, 1'b0, 1'b1, 1'b0));
        send(1'b0, 6'd15, 10'h005, 3'b000, RNE, 1'b0, 16'h0, mk(16'h3C05, 1'b0, 1'b0, 1'b0));
        drain();
        check("flags_nx_only", {30'd0, flags_acc}, 32'd1);

        // Clear coincident with an overflow completion keeps the new flags
        send(1'b0, 6'd30, 10'h3FF, 3'b110, RNE, 1'b0, 16'h0, mk(16'h7C00, 1'b1, 1'b1, 1'b1));
        @(posedge clk); #1;
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        check("flags_clr_with_ovf", {30'd0, flags_acc}, 32'd3);
        drain();

        // Bypass, then counter saturation from a fresh reset
        apply_reset();
        send(1'b0, 6'd15, 10'h000, 3'b111, RNA, 1'b1, 16'h7E00, mk(16'h7E00, 1'b0, 1'b0, 1'b0));
        drain();
        check("bypass_flags", {30'd0, flags_acc}, 32'd0);
        check("bypass_no_count", {30'd0, roundup_cnt}, 32'd0);
        for (int n = 0; n < 5; n++)
            send(1'b0, 6'd15, 10'h010, 3'b100, RNA, 1'b0, 16'h0, mk(16'h3C11, 1'b0, 1'b1, 1'b1));
        drain();
        check("cnt_saturates", {30'd0, roundup_cnt}, 32'd3);

        // Backpressure: four back-to-back inputs against a stalled consumer
        out_ready = 1'b0;
        bp_done = 1'b0;
        snap = accepted;
        fork
            begin
                send_m(1'b0, 6'd16, 10'h001, 3'b100, RNE);
                send_m(1'b0, 6'd16, 10'h002, 3'b101, RNE);
                send_m(1'b1, 6'd17, 10'h003, 3'b011, RN);
                send_m(1'b0, 6'd18, 10'h004, 3'b100, RNA);
                bp_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_two_accepted", 32'(accepted - snap), 32'd2);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        hold = out_result;
        repeat (3) begin
            @(negedge clk);
            check("bp_still_blocked", {31'd0, in_ready}, 32'd0);
            check("bp_result_stable", {16'd0, out_result}, {16'd0, hold});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_consecutive", {31'd0, out_valid}, 32'd1);
        end
        for (int i = 0; i < 50 && !bp_done; i++) @(posedge clk);
        check("bp_sender_done", {31'd0, bp_done}, 32'd1);
        drain();

        // Random traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 60; n++) send_rand();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send_m(1'b0, 6'd20, 10'h111, 3'b010, RNE);
        send_m(1'b0, 6'd21, 10'h222, 3'b110, RNE);
        check("inflight_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_kills_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("reset_valid_edge", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_reset_result", {16'd0, out_result}, 32'd0);
        snap = emitted;
        repeat (5) @(posedge clk);
        #1;
        check("no_ghost_output", 32'(emitted), 32'(snap));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
